input_capture_bank: RTL

Parametrised multi-channel input capture stage: WIDTH asynchronous inputs pass through a synchroniser, a per-channel debounce filter and edge detector. A mode-selectable output register then presents them on a registered output bus. It replaces ad-hoc banks of single flops between pad inputs and tile logic. It adds metastability protection, glitch rejection, sample-and-hold, sticky-edge capture and toggle modes.

---
 rtl/input_capture_bank.sv | 90 +++++++++
 1 files changed

// File: rtl/input_capture_bank.sv
// Multi-channel input capture: synchroniser, per-channel debounce filter, edge
// detector and a mode-selectable registered output (follow/hold/sticky/toggle).
module input_capture_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic             sample,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_event
);

    localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_FOLLOW = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_STICKY = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt    [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] f_d;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: the chain is a handful of flops, not a RAM, so resetting every
    // stage is cheap and keeps a channel held high through reset reporting a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // NOTE: non-blocking assignments let every channel read the pre-edge f and
    // cnt, so loop order cannot leak one channel's update into another.
    always_ff @(posedge clk) begin
        if (rst) begin
            f   <= '0;
            f_d <= '0;
            for (int ch = 0; ch < WIDTH; ch++) cnt[ch] <= '0;
        end else begin
            f_d <= f;
            for (int ch = 0; ch < WIDTH; ch++) begin
                if (s[ch] == f[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == CNT_LAST) begin
                    f[ch]   <= s[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Decoded from two registers only, so the pulses are glitch-free.
    assign rise      = f & ~f_d;
    assign fall      = ~f & f_d;
    assign any_event = |(rise | fall);

    // clear is applied before the rise term so a same-cycle edge is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            unique case (mode_t'(mode))
                MODE_FOLLOW: dout <= f;
                MODE_HOLD:   if (sample) dout <= f;
                MODE_STICKY: dout <= (clear ? '0 : dout) | rise;
                MODE_TOGGLE: dout <= (clear ? '0 : dout) ^ rise;
            endcase
        end
    end

endmodule
